issue_instr_queue: RTL and testbench

//  Decoupling FIFO between the decode stage and the issue stage.
//  - Accepts decoded instructions from the ID stage with a valid/ack handshake.
//  - Each entry carries the scoreboard entry, the original 32-bit instruction and the control-flow flag.
//  - Presents entries in order to the issue stage and absorbs issue-side backpressure.
//  - Drops all contents on an unissued-instruction flush.

---
 rtl/issue_instr_queue.sv | 132 +++++++++++++
 tb/tb_issue_instr_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_instr_queue.sv
// ----------------------------------------------------------------------------
// issue_instr_queue
//
// Decoupling FIFO between the decode stage and the issue stage. Each entry
// holds the packed scoreboard entry, the raw 32-bit instruction and a
// control-flow flag. Entries leave strictly in arrival order. The queue
// absorbs issue-side backpressure, and a flush drops everything it holds.
//
// Ports
//   clk_i              core clock
//   rst_ni             synchronous reset, active low (control state only)
//   flush_i            drop all queued entries; blocks both handshakes
//   stall_i            masks issue_valid_o; pushes keep flowing
//   decoded_instr_i    scoreboard entry from ID stage
//   orig_instr_i       raw instruction from ID stage
//   is_ctrl_flow_i     incoming instruction is a branch/jump
//   decoded_valid_i    ID stage offers an entry
//   decoded_ack_o      entry accepted this cycle (combinational)
//   issue_instr_o      head scoreboard entry
//   issue_orig_o       head raw instruction
//   issue_ctrl_flow_o  head control-flow flag
//   issue_valid_o      head entry is valid (combinational)
//   issue_ack_i        issue stage consumed the head
//   occupancy_o        number of valid entries, 0..DEPTH
//   ctrl_flow_cnt_o    number of queued control-flow entries
// ----------------------------------------------------------------------------
module issue_instr_queue #(
    parameter int DEPTH = 4,
    parameter int SBE_W = 128
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           stall_i,
    input  logic [SBE_W-1:0]               decoded_instr_i,
    input  logic [31:0]                    orig_instr_i,
    input  logic                           is_ctrl_flow_i,
    input  logic                           decoded_valid_i,
    output logic                           decoded_ack_o,
    output logic [SBE_W-1:0]               issue_instr_o,
    output logic [31:0]                    issue_orig_o,
    output logic                           issue_ctrl_flow_o,
    output logic                           issue_valid_o,
    input  logic                           issue_ack_i,
    output logic [$clog2(DEPTH):0]         occupancy_o,
    output logic [$clog2(DEPTH):0]         ctrl_flow_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    // Payload storage: written on push, never reset.
    logic [SBE_W-1:0] sbe_mem  [DEPTH];
    logic [31:0]      orig_mem [DEPTH];
    logic             cf_mem   [DEPTH];

    // Control state.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic [PTR_W:0]   cf_cnt;

    logic push;
    logic pop;
    logic cf_inc;
    logic cf_dec;

    // Both handshakes are held off while reset is asserted so that a reset
    // mid-operation behaves like a flush: nothing enters or leaves.
    assign issue_valid_o = rst_ni && (occ != '0) && !stall_i && !flush_i;
    assign pop           = issue_valid_o && issue_ack_i;
    // A full queue may still accept when the head leaves in the same cycle.
    assign decoded_ack_o = rst_ni && !flush_i && ((occ < DEPTH_C) || pop);
    assign push          = decoded_valid_i && decoded_ack_o;

    assign cf_inc = push && is_ctrl_flow_i;
    assign cf_dec = pop && cf_mem[rd_ptr];

    // No bypass: the head always comes from storage.
    assign issue_instr_o     = sbe_mem[rd_ptr];
    assign issue_orig_o      = orig_mem[rd_ptr];
    assign issue_ctrl_flow_o = cf_mem[rd_ptr];

    assign occupancy_o     = occ;
    assign ctrl_flow_cnt_o = cf_cnt;

    always_ff @(posedge clk_i) begin
        if (push) begin
            sbe_mem[wr_ptr]  <= decoded_instr_i;
            orig_mem[wr_ptr] <= orig_instr_i;
            cf_mem[wr_ptr]   <= is_ctrl_flow_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            cf_cnt <= '0;
        end else if (flush_i) begin
            // Empty the queue by catching the read pointer up to the writer.
            rd_ptr <= wr_ptr;
            occ    <= '0;
            cf_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            case ({cf_inc, cf_dec})
                2'b10:   cf_cnt <= cf_cnt + 1'b1;
                2'b01:   cf_cnt <= cf_cnt - 1'b1;
                default: cf_cnt <= cf_cnt;
            endcase
        end
    end

    a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        occ <= DEPTH_C);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (occ == DEPTH_C) && !pop));
    a_cf_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cf_cnt <= occ);

endmodule

// File: tb/tb_issue_instr_queue.sv
// ----------------------------------------------------------------------------
// tb_issue_instr_queue
//
// Directed bench for issue_instr_queue: reset, fill/drain ordering, full
// pass-through, wrap-around streaming, flush, and stall followed by reset.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_issue_instr_queue;

    localparam int DEPTH = 4;
    localparam int SBE_W = 128;
    localparam int PTR_W = 2;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic              stall_i;
    logic [SBE_W-1:0]  decoded_instr_i;
    logic [31:0]       orig_instr_i;
    logic              is_ctrl_flow_i;
    logic              decoded_valid_i;
    logic              decoded_ack_o;
    logic [SBE_W-1:0]  issue_instr_o;
    logic [31:0]       issue_orig_o;
    logic              issue_ctrl_flow_o;
    logic              issue_valid_o;
    logic              issue_ack_i;
    logic [PTR_W:0]    occupancy_o;
    logic [PTR_W:0]    ctrl_flow_cnt_o;

    int checks = 0;
    int errors = 0;

    issue_instr_queue #(.DEPTH(DEPTH), .SBE_W(SBE_W)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .stall_i           (stall_i),
        .decoded_instr_i   (decoded_instr_i),
        .orig_instr_i      (orig_instr_i),
        .is_ctrl_flow_i    (is_ctrl_flow_i),
        .decoded_valid_i   (decoded_valid_i),
        .decoded_ack_o     (decoded_ack_o),
        .issue_instr_o     (issue_instr_o),
        .issue_orig_o      (issue_orig_o),
        .issue_ctrl_flow_o (issue_ctrl_flow_o),
        .issue_valid_o     (issue_valid_o),
        .issue_ack_i       (issue_ack_i),
        .occupancy_o       (occupancy_o),
        .ctrl_flow_cnt_o   (ctrl_flow_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] orig, input logic cf);
        decoded_valid_i = 1'b1;
        orig_instr_i    = orig;
        decoded_instr_i = {4{orig}};
        is_ctrl_flow_i  = cf;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] orig, input logic cf);
        chkn({tag, "_valid"}, 32'(issue_valid_o), 32'd1);
        chkn({tag, "_orig"}, issue_orig_o, orig);
        chk({tag, "_sbe"}, issue_instr_o, {4{orig}});
        chkn({tag, "_cf"}, 32'(issue_ctrl_flow_o), 32'(cf));
    endtask

    logic [31:0] fill_v [4];
    logic [31:0] g_v    [4];
    logic [31:0] exp_v;

    initial begin
        rst_ni          = 1'b0;
        flush_i         = 1'b0;
        stall_i         = 1'b0;
        decoded_valid_i = 1'b0;
        decoded_instr_i = '0;
        orig_instr_i    = '0;
        is_ctrl_flow_i  = 1'b0;
        issue_ack_i     = 1'b0;
        fill_v = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
        g_v    = '{32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003};

        // Reset: an offer during reset must not be accepted
        offer(32'hDEAD_0000, 1'b1);
        #1;
        chkn("rst_ack", 32'(decoded_ack_o), 32'd0);
        chkn("rst_valid", 32'(issue_valid_o), 32'd0);
        tick();
        tick();
        chkn("rst_occ", 32'(occupancy_o), 32'd0);
        chkn("rst_cf", 32'(ctrl_flow_cnt_o), 32'd0);
        rst_ni          = 1'b1;
        decoded_valid_i = 1'b0;
        #1;
        chkn("rst_rel_valid", 32'(issue_valid_o), 32'd0);

        // Fill A..D with no issue ack; odd-indexed entries are control flow
        for (int k = 0; k < 4; k++) begin
            offer(fill_v[k], (k % 2) == 1);
            #1;
            chkn("fill_ack", 32'(decoded_ack_o), 32'd1);
            tick();
        end
        offer(32'hE000_0005, 1'b0);
        #1;
        chkn("fill_5th_ack", 32'(decoded_ack_o), 32'd0);
        chkn("fill_occ", 32'(occupancy_o), 32'd4);
        chkn("fill_cf", 32'(ctrl_flow_cnt_o), 32'd2);
        chk_head("fill_head", fill_v[0], 1'b0);
        tick();
        chkn("fill_hold_occ", 32'(occupancy_o), 32'd4);
        chk_head("fill_stable", fill_v[0], 1'b0);

        // Drain in order
        decoded_valid_i = 1'b0;
        issue_ack_i     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_head("drain", fill_v[k], (k % 2) == 1);
            tick();
        end
        issue_ack_i = 1'b0;
        #1;
        chkn("drain_occ", 32'(occupancy_o), 32'd0);
        chkn("drain_valid", 32'(issue_valid_o), 32'd0);
        chkn("drain_cf", 32'(ctrl_flow_cnt_o), 32'd0);

        // Full pass-through: push E in the same cycle the head pops
        for (int k = 0; k < 4; k++) begin
            offer(g_v[k], 1'b0);
            tick();
        end
        offer(32'h0E0E_0E0E, 1'b1);
        issue_ack_i = 1'b1;
        #1;
        chkn("pt_ack", 32'(decoded_ack_o), 32'd1);
        chk_head("pt_head0", g_v[0], 1'b0);
        tick();
        decoded_valid_i = 1'b0;
        issue_ack_i     = 1'b0;
        #1;
        chkn("pt_occ", 32'(occupancy_o), 32'd4);
        chkn("pt_cf", 32'(ctrl_flow_cnt_o), 32'd1);
        chk_head("pt_head1", g_v[1], 1'b0);
        issue_ack_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk_head("pt_drain", g_v[k], 1'b0);
            tick();
        end
        #1;
        chk_head("pt_wrapped_e", 32'h0E0E_0E0E, 1'b1);
        tick();
        issue_ack_i = 1'b0;
        #1;
        chkn("pt_end_occ", 32'(occupancy_o), 32'd0);

        // Wrap-around: stream 10 entries with one push and one pop per cycle
        offer(32'h0000_0013, 1'b0);
        tick();
        issue_ack_i = 1'b1;
        for (int i = 1; i < 10; i++) begin
            offer(32'h0000_0013 + 32'(i), 1'b0);
            #1;
            chkn("wrap_ack", 32'(decoded_ack_o), 32'd1);
            exp_v = 32'h0000_0013 + 32'(i - 1);
            chkn("wrap_head", issue_orig_o, exp_v);
            tick();
            chkn("wrap_occ", 32'(occupancy_o), 32'd1);
        end
        decoded_valid_i = 1'b0;
        #1;
        chk_head("wrap_last", 32'h0000_001C, 1'b0);
        tick();
        issue_ack_i = 1'b0;
        #1;
        chkn("wrap_end_occ", 32'(occupancy_o), 32'd0);

        // Flush with 3 entries (one control flow) and a concurrent push offer
        offer(32'h7000_0000, 1'b0);
        tick();
        offer(32'h7000_0001, 1'b1);
        tick();
        offer(32'h7000_0002, 1'b0);
        tick();
        decoded_valid_i = 1'b0;
        #1;
        chkn("fl_pre_occ", 32'(occupancy_o), 32'd3);
        chkn("fl_pre_cf", 32'(ctrl_flow_cnt_o), 32'd1);
        offer(32'h7000_0003, 1'b1);
        flush_i     = 1'b1;
        issue_ack_i = 1'b1;
        #1;
        chkn("fl_ack", 32'(decoded_ack_o), 32'd0);
        chkn("fl_valid", 32'(issue_valid_o), 32'd0);
        tick();
        flush_i         = 1'b0;
        decoded_valid_i = 1'b0;
        issue_ack_i     = 1'b0;
        #1;
        chkn("fl_occ", 32'(occupancy_o), 32'd0);
        chkn("fl_cf", 32'(ctrl_flow_cnt_o), 32'd0);
        chkn("fl_valid_after", 32'(issue_valid_o), 32'd0);
        offer(32'h8000_0001, 1'b1);
        tick();
        decoded_valid_i = 1'b0;
        #1;
        chk_head("fl_next_head", 32'h8000_0001, 1'b1);
        chkn("fl_next_cf", 32'(ctrl_flow_cnt_o), 32'd1);
        issue_ack_i = 1'b1;
        tick();
        issue_ack_i = 1'b0;

        // Stall: valid masked, acks ignored, pushes fill the queue
        stall_i     = 1'b1;
        issue_ack_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer(32'h9000_0000 + 32'(k), 1'b0);
            #1;
            chkn("st_ack", 32'(decoded_ack_o), 32'd1);
            chkn("st_valid", 32'(issue_valid_o), 32'd0);
            tick();
            if (k == 1) chkn("st_occ2", 32'(occupancy_o), 32'd2);
        end
        offer(32'h9000_0004, 1'b0);
        #1;
        chkn("st_full_ack", 32'(decoded_ack_o), 32'd0);
        chkn("st_occ4", 32'(occupancy_o), 32'd4);
        chkn("st_full_valid", 32'(issue_valid_o), 32'd0);

        // Reset mid-operation discards everything
        stall_i = 1'b0;
        rst_ni  = 1'b0;
        #1;
        chkn("mrst_ack", 32'(decoded_ack_o), 32'd0);
        tick();
        rst_ni          = 1'b1;
        decoded_valid_i = 1'b0;
        issue_ack_i     = 1'b0;
        #1;
        chkn("mrst_occ", 32'(occupancy_o), 32'd0);
        chkn("mrst_valid", 32'(issue_valid_o), 32'd0);
        chkn("mrst_cf", 32'(ctrl_flow_cnt_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
